// File: rtl/mem_ctrl_if.sv
// Core-side and RAM-side signal bundle for mem_ctrl.
// The master modport is the core (IF/MEM stages); the ram modport is the byte-wide RAM.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_done;
  logic [31:0]       if_data;
  logic              mm_req;
  logic              mm_we;
  logic [2:0]        mm_st;
  logic [31:0]       mm_addr;
  logic [31:0]       mm_wdata;
  logic              mm_done;
  logic [31:0]       mm_rdata;
  logic              stl_mm;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_rw;

  modport master (
    output if_req, if_addr, if_flush, mm_req, mm_we, mm_st, mm_addr, mm_wdata,
    input  if_done, if_data, mm_done, mm_rdata, stl_mm
  );

  modport slave (
    input  if_req, if_addr, if_flush, mm_req, mm_we, mm_st, mm_addr, mm_wdata, ram_din,
    output if_done, if_data, mm_done, mm_rdata, stl_mm, ram_dout, ram_a, ram_rw
  );

  modport ram (
    input  ram_a, ram_rw, ram_dout,
    output ram_din
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte RAM arbiter/serialiser shared by instruction fetch and the memory stage.
// MEM has priority; transactions are split into per-byte RAM cycles, little-endian.
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e            state_q, state_d;
  logic              owner_mm_q, owner_mm_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic              zext_q, zext_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mm_rdata_q, mm_rdata_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_rw_q, ram_rw_d;
  logic              if_done_q, if_done_d;
  logic              mm_done_q, mm_done_d;
  logic [31:0]       ext;
  logic [2:0]        cnt_inc;
  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;

  function automatic logic [2:0] len_of(input logic [1:0] sz);
    case (sz)
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // cnt counts edges since the grant edge; byte cnt-1 arrives on ram_din each RD step.
  assign cnt_inc = cnt_q + 3'd1;
  assign rd_idx  = 2'(cnt_q - 3'd1);
  assign wr_idx  = 2'(cnt_inc);

  always_comb begin
    state_d    = state_q;
    owner_mm_d = owner_mm_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    zext_d     = zext_q;
    base_d     = base_q;
    ram_a_d    = ram_a_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    if_data_d  = if_data_q;
    mm_rdata_d = mm_rdata_q;
    ram_dout_d = ram_dout_q;
    ram_rw_d   = ram_rw_q;
    if_done_d  = 1'b0;
    mm_done_d  = 1'b0;
    ext        = '0;

    unique case (state_q)
      StIdle: begin
        // One-cycle turnaround: no grant while a done pulse is visible.
        if (!if_done_q && !mm_done_q) begin
          if (bus.mm_req) begin
            owner_mm_d = 1'b1;
            base_d     = bus.mm_addr[ADDR_W-1:0];
            ram_a_d    = bus.mm_addr[ADDR_W-1:0];
            len_d      = len_of(bus.mm_st[1:0]);
            zext_d     = bus.mm_st[2];
            wdata_d    = bus.mm_wdata;
            rbuf_d     = '0;
            cnt_d      = '0;
            if (bus.mm_we) begin
              state_d    = StWr;
              ram_rw_d   = 1'b1;
              ram_dout_d = bus.mm_wdata[7:0];
            end else begin
              state_d  = StRd;
              ram_rw_d = 1'b0;
            end
          end else if (bus.if_req && !bus.if_flush) begin
            owner_mm_d = 1'b0;
            base_d     = bus.if_addr[ADDR_W-1:0];
            ram_a_d    = bus.if_addr[ADDR_W-1:0];
            len_d      = 3'd4;
            zext_d     = 1'b0;
            rbuf_d     = '0;
            cnt_d      = '0;
            state_d    = StRd;
            ram_rw_d   = 1'b0;
          end
        end
      end

      StRd: begin
        if (!owner_mm_q && bus.if_flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) ram_a_d = base_q + ADDR_W'(cnt_inc);
          if (cnt_q != 3'd0) rbuf_d[{rd_idx, 3'b000} +: 8] = bus.ram_din;
          if (cnt_q == len_q) begin
            state_d = StIdle;
            cnt_d   = '0;
            unique case (len_q)
              3'd1:    ext = zext_q ? {24'h0, rbuf_d[7:0]} : {{24{rbuf_d[7]}}, rbuf_d[7:0]};
              3'd2:    ext = zext_q ? {16'h0, rbuf_d[15:0]} : {{16{rbuf_d[15]}}, rbuf_d[15:0]};
              default: ext = rbuf_d;
            endcase
            if (owner_mm_q) begin
              mm_done_d  = 1'b1;
              mm_rdata_d = ext;
            end else begin
              if_done_d = 1'b1;
              if_data_d = rbuf_d;
            end
          end
        end
      end

      StWr: begin
        cnt_d = cnt_inc;
        if (cnt_inc < len_q) begin
          ram_a_d    = base_q + ADDR_W'(cnt_inc);
          ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
        end else begin
          ram_rw_d  = 1'b0;
          mm_done_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_mm_q <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      zext_q     <= 1'b0;
      base_q     <= '0;
      ram_a_q    <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      if_data_q  <= '0;
      mm_rdata_q <= '0;
      ram_dout_q <= '0;
      ram_rw_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_mm_q <= owner_mm_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      zext_q     <= zext_d;
      base_q     <= base_d;
      ram_a_q    <= ram_a_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      if_data_q  <= if_data_d;
      mm_rdata_q <= mm_rdata_d;
      ram_dout_q <= ram_dout_d;
      ram_rw_q   <= ram_rw_d;
      if_done_q  <= if_done_d;
      mm_done_q  <= mm_done_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.mm_done  = mm_done_q;
  assign bus.mm_rdata = mm_rdata_q;
  assign bus.ram_a    = ram_a_q;
  assign bus.ram_rw   = ram_rw_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.stl_mm   = bus.mm_req && !mm_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, scoreboard queues for read data,
// a table of MEM vectors and hand-written timing sequences.
module tb_mem_ctrl;
  localparam int unsigned ADDR_W = 32;
  localparam bit [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  typedef struct {
    bit        we;
    bit [2:0]  st;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp;
  } vec_t;

  typedef struct {
    bit        is_load;
    bit [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  bit [31:0] exp_if[$];
  sb_t       exp_mm[$];
  vec_t      vecs[$];
  bit [7:0]  mem [0:4095];

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous byte RAM; low 12 address bits so wrapped addresses land at 0x000/0x001.
  always @(posedge clk) begin
    bus.ram_din <= mem[bus.ram_a[11:0]];
    if (bus.ram_rw) mem[bus.ram_a[11:0]] <= bus.ram_dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.if_done === 1'b1) begin
        if (exp_if.size() == 0) chk("if_done_spurious", {31'b0, bus.if_done}, 32'd0);
        else chk("if_data", bus.if_data, exp_if.pop_front());
      end
      if (bus.mm_done === 1'b1) begin
        if (exp_mm.size() == 0) chk("mm_done_spurious", {31'b0, bus.mm_done}, 32'd0);
        else begin
          sb_t e;
          e = exp_mm.pop_front();
          if (e.is_load) chk("mm_rdata", bus.mm_rdata, e.data);
        end
      end
    end
  end

  task automatic wait_mm_done();
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.mm_done) break;
    end
    chk("mm_done_seen", {31'b0, bus.mm_done}, 32'd1);
  endtask

  task automatic wait_if_done();
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.if_done) break;
    end
    chk("if_done_seen", {31'b0, bus.if_done}, 32'd1);
  endtask

  task automatic mm_op(input bit we, input bit [2:0] st, input bit [31:0] addr,
                       input bit [31:0] wdata, input bit [31:0] exp);
    bit stall_ok;
    stall_ok     = 1'b1;
    bus.mm_we    = we;
    bus.mm_st    = st;
    bus.mm_addr  = addr;
    bus.mm_wdata = wdata;
    bus.mm_req   = 1'b1;
    exp_mm.push_back('{is_load: !we, data: exp});
    #1;
    if (!bus.stl_mm) stall_ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.mm_done) break;
      if (!bus.stl_mm) stall_ok = 1'b0;
    end
    chk("mm_done_seen", {31'b0, bus.mm_done}, 32'd1);
    chk("stl_mm_while_busy", {31'b0, stall_ok}, 32'd1);
    chk("stl_mm_done_cycle", {31'b0, bus.stl_mm}, 32'd0);
    bus.mm_req = 1'b0;
    step();
    chk("mm_done_one_cycle", {31'b0, bus.mm_done}, 32'd0);
  endtask

  task automatic if_op(input bit [31:0] addr, input bit [31:0] exp);
    exp_if.push_back(exp);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    wait_if_done();
    bus.if_req = 1'b0;
    step();
    chk("if_done_one_cycle", {31'b0, bus.if_done}, 32'd0);
  endtask

  initial begin
    bit [31:0] w;
    bit [31:0] a;
    bit        quiet;

    vecs.push_back('{1, F_B,  32'h200, 32'h80,       32'h0});
    vecs.push_back('{0, F_B,  32'h200, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{0, F_BU, 32'h200, 32'h0,        32'h00000080});
    vecs.push_back('{1, F_H,  32'h210, 32'h8001,     32'h0});
    vecs.push_back('{0, F_H,  32'h210, 32'h0,        32'hFFFF8001});
    vecs.push_back('{0, F_HU, 32'h210, 32'h0,        32'h00008001});
    vecs.push_back('{0, F_W,  32'h300, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{0, F_B,  32'h301, 32'h0,        32'hFFFFFFBE});
    vecs.push_back('{0, F_H,  32'h301, 32'h0,        32'hFFFFADBE});
    vecs.push_back('{0, F_HU, 32'h302, 32'h0,        32'h0000DEAD});
    vecs.push_back('{0, F_BU, 32'h303, 32'h0,        32'h000000DE});
    vecs.push_back('{1, F_W,  32'h305, 32'h12345678, 32'h0});
    vecs.push_back('{0, F_W,  32'h305, 32'h0,        32'h12345678});
    vecs.push_back('{1, F_H,  32'h220, 32'h1234,     32'h0});
    vecs.push_back('{0, F_H,  32'h220, 32'h0,        32'h00001234});

    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.mm_req   = 1'b0;
    bus.mm_we    = 1'b0;
    bus.mm_st    = '0;
    bus.mm_addr  = '0;
    bus.mm_wdata = '0;
    repeat (3) step();
    chk("rst_if_done",  {31'b0, bus.if_done}, 32'd0);
    chk("rst_mm_done",  {31'b0, bus.mm_done}, 32'd0);
    chk("rst_ram_rw",   {31'b0, bus.ram_rw}, 32'd0);
    chk("rst_ram_a",    bus.ram_a, 32'd0);
    chk("rst_ram_dout", {24'b0, bus.ram_dout}, 32'd0);
    chk("rst_if_data",  bus.if_data, 32'd0);
    chk("rst_mm_rdata", bus.mm_rdata, 32'd0);
    chk("rst_stl_mm",   {31'b0, bus.stl_mm}, 32'd0);
    rst = 1'b0;
    step();

    // Preload instruction words through the controller.
    mm_op(1, F_W, 32'h100, 32'h00000513, 0);
    mm_op(1, F_W, 32'h400, 32'h00A00093, 0);

    // IF word read: address walk and done latency.
    exp_if.push_back(32'h00000513);
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      a = 32'h100 + 32'(k);
      chk("if_ram_a", bus.ram_a, a);
      chk("if_ram_rw", {31'b0, bus.ram_rw}, 32'd0);
    end
    step();
    chk("if_done_e4", {31'b0, bus.if_done}, 32'd0);
    step();
    chk("if_done_e5", {31'b0, bus.if_done}, 32'd1);
    bus.if_req = 1'b0;
    step();

    // SW byte sequence.
    w = 32'hDEADBEEF;
    exp_mm.push_back('{is_load: 1'b0, data: 32'h0});
    bus.mm_we = 1'b1; bus.mm_st = F_W; bus.mm_addr = 32'h300; bus.mm_wdata = w;
    bus.mm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      a = 32'h300 + 32'(k);
      chk("sw_ram_rw", {31'b0, bus.ram_rw}, 32'd1);
      chk("sw_ram_a", bus.ram_a, a);
      chk("sw_ram_dout", {24'b0, bus.ram_dout}, {24'b0, w[8*k +: 8]});
    end
    step();
    chk("sw_rw_low", {31'b0, bus.ram_rw}, 32'd0);
    chk("sw_done_e4", {31'b0, bus.mm_done}, 32'd1);
    bus.mm_req = 1'b0;
    step();

    for (int i = 0; i < vecs.size(); i++)
      mm_op(vecs[i].we, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Simultaneous requests: MEM first, IF after the turnaround cycle.
    exp_mm.push_back('{is_load: 1'b1, data: 32'hDEADBEEF});
    exp_if.push_back(32'h00000513);
    bus.mm_we = 1'b0; bus.mm_st = F_W; bus.mm_addr = 32'h300; bus.mm_req = 1'b1;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    step();
    chk("arb_mm_first", bus.ram_a, 32'h300);
    wait_mm_done();
    bus.mm_req = 1'b0;
    step();
    chk("arb_no_grant_done_cycle", bus.ram_a, 32'h303);
    step();
    chk("arb_if_granted", bus.ram_a, 32'h100);
    wait_if_done();
    bus.if_req = 1'b0;
    step();

    // Flush mid IF read, MEM waiting.
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    repeat (3) step();
    bus.if_flush = 1'b1;
    exp_mm.push_back('{is_load: 1'b1, data: 32'h00000080});
    bus.mm_we = 1'b0; bus.mm_st = F_BU; bus.mm_addr = 32'h200; bus.mm_req = 1'b1;
    step();
    chk("flush_no_if_done", {31'b0, bus.if_done}, 32'd0);
    step();
    chk("flush_mm_granted", bus.ram_a, 32'h200);
    bus.if_req = 1'b0;
    bus.if_flush = 1'b0;
    wait_mm_done();
    bus.mm_req = 1'b0;
    step();
    if_op(32'h400, 32'h00A00093);

    // Reset during the second byte of a store.
    bus.mm_we = 1'b1; bus.mm_st = F_W; bus.mm_addr = 32'h300; bus.mm_wdata = 32'h11223344;
    bus.mm_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_rw", {31'b0, bus.ram_rw}, 32'd0);
    chk("rst_mid_done", {31'b0, bus.mm_done}, 32'd0);
    chk("rst_mid_ram_a", bus.ram_a, 32'd0);
    rst = 1'b0;
    bus.mm_req = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      step();
      if (bus.mm_done) quiet = 1'b0;
    end
    chk("rst_mid_no_done", {31'b0, quiet}, 32'd1);

    // Address wrap on a word store, then read back.
    exp_mm.push_back('{is_load: 1'b0, data: 32'h0});
    bus.mm_we = 1'b1; bus.mm_st = F_W; bus.mm_addr = 32'hFFFFFFFE; bus.mm_wdata = 32'hCAFEF00D;
    bus.mm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      a = 32'hFFFFFFFE + 32'(k);
      chk("wrap_ram_a", bus.ram_a, a);
    end
    step();
    chk("wrap_done", {31'b0, bus.mm_done}, 32'd1);
    bus.mm_req = 1'b0;
    step();
    mm_op(0, F_W, 32'hFFFFFFFE, 0, 32'hCAFEF00D);

    repeat (4) step();
    chk("sb_if_drained", 32'(exp_if.size()), 32'd0);
    chk("sb_mm_drained", 32'(exp_mm.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
